msk_tx_mod: RTL and testbench

//  Baseband MSK modulator: transmit-side counterpart of the MSK receive chain (MF/Gardner/slicer).

---
 rtl/msk_tx_mod.sv | 111 +++++++++++
 tb/tb_msk_tx_mod.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_tx_mod.sv
// Baseband MSK modulator: one data bit per symbol in, continuous-phase I/Q out at OSF samples/symbol.
// The phase index walks a 4*OSF-entry cos/sin table by +/-1 per sample, i.e. +/-pi/2 per symbol.
module msk_tx_mod #(
  parameter int OSF     = 20,
  parameter int OW      = 16,
  parameter int AMP     = 16384,
  parameter int PRECODE = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 samp_en_i,
  input  logic                 data_i,
  input  logic                 data_val_i,
  output logic                 data_rdy_o,
  output logic signed [OW-1:0] i_o,
  output logic signed [OW-1:0] q_o,
  output logic                 iq_val_o,
  output logic                 sym_stb_o,
  output logic                 busy_o,
  output logic                 underflow_o
);

  localparam int  N  = 4 * OSF;
  localparam int  PW = $clog2(N);
  localparam int  CW = (OSF > 1) ? $clog2(OSF) : 1;
  localparam real PI = 3.14159265358979323846;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    p_q, p_step;
  logic [CW-1:0]    cnt_q;
  logic             dir_q, prev_q;
  logic             last, accept, f_bit, step_dir, advance, boundary;

  logic signed [OW-1:0] lut_i [N];
  logic signed [OW-1:0] lut_q [N];

  // Table is constant at elaboration; rounding is half away from zero.
  for (genvar n = 0; n < N; n++) begin : g_lut
    localparam real CV = AMP * $cos(2.0 * PI * n / N);
    localparam real SV = AMP * $sin(2.0 * PI * n / N);
    localparam int  CI = (CV >= 0.0) ? $rtoi(CV + 0.5) : -$rtoi(0.5 - CV);
    localparam int  SI = (SV >= 0.0) ? $rtoi(SV + 0.5) : -$rtoi(0.5 - SV);
    assign lut_i[n] = OW'(CI);
    assign lut_q[n] = OW'(SI);
  end

  assign last     = (cnt_q == CW'(OSF - 1));
  assign boundary = (state_q == RUN) && samp_en_i && last;
  assign accept   = data_val_i && data_rdy_o;
  assign f_bit    = (PRECODE != 0) ? (data_i ^ prev_q) : data_i;
  assign step_dir = accept ? f_bit : dir_q;
  assign advance  = accept || ((state_q == RUN) && samp_en_i && !last);

  always_comb begin
    // NOTE: default assignment first so every path drives p_step and no latch is inferred.
    p_step = p_q;
    if (step_dir)
      p_step = (p_q == PW'(N - 1)) ? '0 : p_q + PW'(1);
    else
      p_step = (p_q == '0) ? PW'(N - 1) : p_q - PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)        state_d = RUN;
    else if (boundary) state_d = IDLE;
  end

  always_comb begin
    busy_o     = (state_q == RUN);
    data_rdy_o = reset_n && samp_en_i && ((state_q == IDLE) || ((state_q == RUN) && last));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_q         <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      prev_q      <= 1'b0;
      i_o         <= '0;
      q_o         <= '0;
      iq_val_o    <= 1'b0;
      sym_stb_o   <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      iq_val_o  <= advance;
      sym_stb_o <= accept;
      if (advance) begin
        p_q   <= p_step;
        i_o   <= lut_i[p_step];
        q_o   <= lut_q[p_step];
        cnt_q <= accept ? '0 : cnt_q + CW'(1);
      end
      if (accept) begin
        dir_q  <= f_bit;
        prev_q <= data_i;
      end
      // Symbol ended with nothing queued: flag it, sticky until reset.
      if (boundary && !accept) underflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_msk_tx_mod.sv
// Self-checking bench for msk_tx_mod: directed scenarios plus random stimulus against a
// phase-accumulator reference model, one DUT without and one with precoding.
module tb_msk_tx_mod;

  localparam int  OSF = 20;
  localparam int  OW  = 16;
  localparam int  AMP = 16384;
  localparam real PI  = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset_n = 1'b0, samp_en = 1'b0, data_in = 1'b0, data_val = 1'b0;
  logic rdy0, rdy1, val0, val1, stb0, stb1, busy0, busy1, uf0, uf1;
  logic signed [OW-1:0] i0, q0, i1, q1;

  always #5 clk = ~clk;

  msk_tx_mod #(.OSF(OSF), .OW(OW), .AMP(AMP), .PRECODE(0)) dut (
    .clk(clk), .reset_n(reset_n), .samp_en_i(samp_en), .data_i(data_in), .data_val_i(data_val),
    .data_rdy_o(rdy0), .i_o(i0), .q_o(q0), .iq_val_o(val0), .sym_stb_o(stb0),
    .busy_o(busy0), .underflow_o(uf0));

  msk_tx_mod #(.OSF(OSF), .OW(OW), .AMP(AMP), .PRECODE(1)) dut_pc (
    .clk(clk), .reset_n(reset_n), .samp_en_i(samp_en), .data_i(data_in), .data_val_i(data_val),
    .data_rdy_o(rdy1), .i_o(i1), .q_o(q1), .iq_val_o(val1), .sym_stb_o(stb1),
    .busy_o(busy1), .underflow_o(uf1));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: integer phase accumulator plus count of samples emitted in the symbol.
  bit m_run [2], m_prev [2], m_uf [2], m_val [2], m_stb [2];
  int m_emit [2], m_ph [2], m_dir [2], m_i [2], m_q [2];

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction
  function automatic int lut_i(input int p);
    return rnd(AMP * $cos(2.0 * PI * p / (4 * OSF)));
  endfunction
  function automatic int lut_q(input int p);
    return rnd(AMP * $sin(2.0 * PI * p / (4 * OSF)));
  endfunction

  function automatic bit exp_rdy(input int k, input bit r, input bit en);
    return r && en && (!m_run[k] || m_emit[k] == OSF);
  endfunction

  function automatic void model_step(input int k, input bit r, input bit en, input bit v, input bit d);
    bit take, f, adv;
    if (!r) begin
      m_run[k] = 0; m_emit[k] = 0; m_ph[k] = 0; m_prev[k] = 0; m_uf[k] = 0;
      m_i[k] = 0; m_q[k] = 0; m_val[k] = 0; m_stb[k] = 0; m_dir[k] = 1;
      return;
    end
    take = exp_rdy(k, r, en) && v;
    adv  = 0;
    m_stb[k] = take;
    m_val[k] = 0;
    if (take) begin
      f = (k == 1) ? (d ^ m_prev[k]) : d;
      m_dir[k]  = f ? 1 : -1;
      m_prev[k] = d;
      m_emit[k] = 1;
      m_run[k]  = 1;
      adv = 1;
    end else if (m_run[k] && en) begin
      if (m_emit[k] < OSF) begin
        m_emit[k]++;
        adv = 1;
      end else begin
        m_uf[k]  = 1;
        m_run[k] = 0;
      end
    end
    if (adv) begin
      m_ph[k]  = (m_ph[k] + m_dir[k] + 4 * OSF) % (4 * OSF);
      m_i[k]   = lut_i(m_ph[k]);
      m_q[k]   = lut_q(m_ph[k]);
      m_val[k] = 1;
    end
  endfunction

  // Per-test capture of emitted samples, indexed from 1.
  int n0, n1;
  int cap_i0 [256], cap_q0 [256], cap_i1 [256], cap_q1 [256];
  bit cap_s0 [256];
  bit seq [$];

  task automatic clear_caps();
    n0 = 0;
    n1 = 0;
  endtask

  task automatic cyc(input bit r, input bit en, input bit v, input bit d, output bit took);
    @(negedge clk);
    reset_n = r; samp_en = en; data_val = v; data_in = d;
    #1;
    check("rdy", rdy0, exp_rdy(0, r, en));
    check("rdy_pc", rdy1, exp_rdy(1, r, en));
    took = v && exp_rdy(0, r, en);
    model_step(0, r, en, v, d);
    model_step(1, r, en, v, d);
    @(posedge clk);
    #1;
    check("iq_val", val0, m_val[0]);   check("iq_val_pc", val1, m_val[1]);
    check("sym_stb", stb0, m_stb[0]);  check("sym_stb_pc", stb1, m_stb[1]);
    check("busy", busy0, m_run[0]);    check("busy_pc", busy1, m_run[1]);
    check("underflow", uf0, m_uf[0]);  check("underflow_pc", uf1, m_uf[1]);
    check("i", i0, m_i[0]);            check("i_pc", i1, m_i[1]);
    check("q", q0, m_q[0]);            check("q_pc", q1, m_q[1]);
    if (val0) begin
      n0++;
      if (n0 < 256) begin cap_i0[n0] = i0; cap_q0[n0] = q0; cap_s0[n0] = stb0; end
    end
    if (val1) begin
      n1++;
      if (n1 < 256) begin cap_i1[n1] = i1; cap_q1[n1] = q1; end
    end
  endtask

  task automatic do_reset(input int cycles);
    bit took;
    for (int i = 0; i < cycles; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, took);
    clear_caps();
  endtask

  task automatic idle(input int cycles, input bit alt);
    bit took;
    for (int i = 0; i < cycles; i++) cyc(1'b1, alt ? (i % 2 == 0) : 1'b1, 1'b0, 1'b0, took);
  endtask

  // Offers seq bit by bit with data_val held; stop_at>0 aborts once the precoded DUT emitted that many samples.
  task automatic run_bits(input bit alt, input int stop_at);
    int idx = 0;
    int c   = 0;
    bit took;
    while (idx < seq.size() && c < 5000 && !(stop_at > 0 && n1 >= stop_at)) begin
      cyc(1'b1, alt ? (c % 2 == 0) : 1'b1, 1'b1, seq[idx], took);
      if (took) idx++;
      c++;
    end
    if (stop_at == 0) check("stream_all_accepted", idx, seq.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit took;
    // T1: reset held with data offered: outputs zero, no handshake.
    do_reset(4);
    @(negedge clk);
    data_val = 1'b0; reset_n = 1'b1; samp_en = 1'b0;
    #1 check("t1_rdy_en0", rdy0, 0);
    samp_en = 1'b1;
    #1 check("t1_rdy_en1", rdy0, 1);

    // T2: single bit 1.
    do_reset(2);
    seq = {1'b1};
    run_bits(1'b0, 0);
    idle(OSF + 3, 1'b0);
    check("t2_count", n0, OSF);
    check("t2_first_i", cap_i0[1], lut_i(1));
    check("t2_last_i", cap_i0[20], 0);
    check("t2_last_q", cap_q0[20], 16384);
    check("t2_underflow", uf0, 1);
    check("t2_busy", busy0, 0);

    // T3: 1,1,0 back to back.
    do_reset(2);
    seq = {1'b1, 1'b1, 1'b0};
    run_bits(1'b0, 0);
    idle(OSF + 3, 1'b0);
    check("t3_count", n0, 3 * OSF);
    check("t3_i40", cap_i0[40], -16384);
    check("t3_q40", cap_q0[40], 0);
    check("t3_q60", cap_q0[60], 16384);
    check("t3_stb1", cap_s0[1], 1);
    check("t3_stb2", cap_s0[2], 0);
    check("t3_stb21", cap_s0[21], 1);
    check("t3_stb41", cap_s0[41], 1);

    // T4: phase wrap.
    do_reset(2);
    seq = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    run_bits(1'b0, 0);
    idle(OSF + 3, 1'b0);
    check("t4_count", n0, 6 * OSF);
    check("t4_i80", cap_i0[80], 16384);
    check("t4_q80", cap_q0[80], 0);
    check("t4_q100", cap_q0[100], 16384);
    check("t4_i120", cap_i0[120], 16384);
    check("t4_q120", cap_q0[120], 0);

    // T5: sample enable every other clock.
    do_reset(2);
    seq = {1'b1, 1'b0, 1'b1};
    run_bits(1'b1, 0);
    check("t5_no_underflow", uf0, 0);
    idle(2 * OSF + 4, 1'b1);
    check("t5_count", n0, 3 * OSF);
    check("t5_underflow_end", uf0, 1);

    // T6: precoded 1,1,0 -> phase 0,20,0,20.
    do_reset(2);
    seq = {1'b1, 1'b1, 1'b0};
    run_bits(1'b0, 0);
    idle(OSF + 3, 1'b0);
    check("t6_q20", cap_q1[20], 16384);
    check("t6_i40", cap_i1[40], 16384);
    check("t6_q40", cap_q1[40], 0);
    check("t6_q60", cap_q1[60], 16384);

    // T6: reset in the middle of the second symbol, then restart from phase 0.
    do_reset(2);
    seq = {1'b1, 1'b1, 1'b0};
    run_bits(1'b0, 30);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, took);
    check("t6_rst_i", i1, 0);
    check("t6_rst_q", q1, 0);
    check("t6_rst_val", val1, 0);
    check("t6_rst_busy", busy1, 0);
    clear_caps();
    seq = {1'b1};
    run_bits(1'b0, 0);
    idle(OSF + 2, 1'b0);
    check("t6_restart_i", cap_i1[1], lut_i(1));
    check("t6_restart_q", cap_q1[1], lut_q(1));

    // Random traffic.
    do_reset(2);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0, 1'($urandom), took);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
